classic_mode: RTL and testbench
===============================

// Module: classic_mode
// PURPOSE
//  Round controller plus serial guess capture for the classic memory game.
//  The FSM sequences each round: pattern generation, user input, compare, and score or game over.
//  An embedded shifter collects the player's serial guess, MSB first, into a 16-bit word.
//  Sits between the pattern generator/comparator (external) and the button/input front end.
// PARAMETERS
//  GUESS_W   16  width of user_guess and count
//  SCORE_W   8   width of score counter (only with CLASSIC_MODE_SCORE_EN)
// PORTS
//  clk               in   1        single clock, all state on rising edge
//  rst_n             in   1        asynchronous, active-low reset
//  start             in   1        begin game (sampled in IDLE)
//  done_gen_pattern  in   1        pattern generator finished (level)
//  is_equal          in   1        comparator result, sampled in CHECK
//  play_again        in   1        restart after game over (sampled in OVER)
//  in                in   1        serial guess bit
//  count             in   GUESS_W  number of bits expected this round
//  gen_pattern       out  1        request pattern generation
//  incr_score        out  1        one-cycle pulse on correct guess
//  clr               out  1        synchronous clear of shifter
//  input_handler_en  out  1        shifter enable
//  received_input    out  1        all count bits captured (level, until clr)
//  user_guess        out  GUESS_W  captured guess, right-justified
// BEHAVIOUR
//  Reset: state=IDLE; user_guess=0, received_input=0, bit counter=0; Moore outputs per IDLE.
//  States (Moore outputs):
//  - IDLE: clr=1. start -> GEN.
//  - GEN: gen_pattern=1, clr=1. done_gen_pattern -> INPUT.
//  - INPUT: input_handler_en=1. received_input -> CHECK.
//  - CHECK: is_equal=1 -> GEN with incr_score=1 this cycle; else -> OVER.
//  - OVER: play_again -> GEN.
//  All outputs not listed for a state are 0.
//  Shifter: clr has priority and zeroes user_guess, bit counter, received_input next edge.
//  - If en=1 and received_input=0: user_guess <= {user_guess[GUESS_W-2:0], in}; cnt++.
//  - received_input registers 1 on the edge where cnt reaches count; shifting then stops.
//  - Example: bits 1,0,1,1,0 with count=5 -> user_guess=16'h0016; received_input=1 after the 5th edge.
//  - count=0: received_input sets on the first enabled edge with no shift.
//  - count>GUESS_W: treated as GUESS_W.
//  - en=0 holds all shifter state.
//  Simultaneous events:
//  - start in non-IDLE states is ignored.
//  - play_again outside OVER is ignored.
//  - Reset mid-round returns to IDLE immediately (async).
// CONFIGURATION
//  CLASSIC_MODE_SCORE_EN defined: adds output score[SCORE_W-1:0].
//  - Reset to 0, cleared on the IDLE->GEN and OVER->GEN transitions.
//  - Increments with incr_score; saturates at all-ones.
//  Undefined: no score port, no counter; all other behaviour identical.
// STRUCTURE
//  Package classic_mode_pkg holds:
//  - state_e enum {IDLE,GEN,INPUT,CHECK,OVER}
//  - GUESS_W_DEF=16, SCORE_W_DEF=8 constants
//  Sub-module guess_shifter: serial-in shift register + bit counter + received flag.
//  - ports: clk, rst_n, in, en, clr, count, received_input, user_guess.
//  classic_mode holds the FSM and instantiates one guess_shifter.
// TESTING
//  1. Reset low, then high:
//     -> state IDLE, clr=1, gen_pattern=0, user_guess=0, received_input=0.
//  2. start pulse, then done_gen_pattern=1 after 3 cycles:
//     -> gen_pattern=1 while in GEN; input_handler_en=1 the cycle after done.
//  3. count=5, bits 1,0,1,1,0 MSB first:
//     -> user_guess=16'h0016, received_input=1.
//     -> one extra cycle with in=1 leaves user_guess unchanged.
//  4. In CHECK with is_equal=1:
//     -> incr_score one-cycle pulse, back to GEN.
//     -> clr=1 zeroes user_guess next edge.
//  5. In CHECK with is_equal=0:
//     -> OVER, all outputs 0.
//     -> play_again=1 -> GEN.
//  6. rst_n low during INPUT mid-shift:
//     -> immediate IDLE, user_guess=0.
//  With CLASSIC_MODE_SCORE_EN: three correct rounds -> score=3; restart from OVER -> score=0.

Source files
------------

// File: rtl/classic_mode_pkg.sv
// Shared types and default widths for the classic memory-game round controller.
package classic_mode_pkg;

    localparam int GUESS_W_DEF = 16;
    localparam int SCORE_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        INPUT = 3'd2,
        CHECK = 3'd3,
        OVER  = 3'd4
    } state_e;

endpackage

// File: rtl/classic_mode_guess_shifter.sv
// Serial-in (MSB first) guess capture with bit counter and sticky received flag.
module guess_shifter #(
    parameter int GUESS_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic               en,
    input  logic               clr,
    input  logic [GUESS_W-1:0] count,
    output logic               received_input,
    output logic [GUESS_W-1:0] user_guess
);

    localparam int CNT_W = $clog2(GUESS_W + 1);

    logic [GUESS_W-1:0] guess_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               received_r;
    logic [CNT_W-1:0]   target_s;
    logic [CNT_W-1:0]   cnt_next_s;

    // Requests longer than the register are clamped to its width.
    always_comb begin
        cnt_next_s = cnt_r + CNT_W'(1);
        if (count > GUESS_W'(GUESS_W)) begin
            target_s = CNT_W'(GUESS_W);
        end else begin
            target_s = CNT_W'(count);
        end
    end

    // Shift state: clear wins, shifting freezes once the target is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guess_r    <= {GUESS_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            received_r <= 1'b0;
        end else if (clr) begin
            guess_r    <= {GUESS_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            received_r <= 1'b0;
        end else if (en && !received_r) begin
            if (target_s == {CNT_W{1'b0}}) begin
                received_r <= 1'b1;
            end else begin
                guess_r    <= {guess_r[GUESS_W-2:0], in};
                cnt_r      <= cnt_next_s;
                received_r <= (cnt_next_s == target_s);
            end
        end
    end

    assign received_input = received_r;
    assign user_guess     = guess_r;

endmodule

// File: rtl/classic_mode.sv
// Round controller FSM for the classic memory game; owns one guess_shifter.
// Optional score counter enabled by defining CLASSIC_MODE_SCORE_EN.
module classic_mode
    import classic_mode_pkg::*;
#(
    parameter int GUESS_W = GUESS_W_DEF
`ifdef CLASSIC_MODE_SCORE_EN
    , parameter int SCORE_W = SCORE_W_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               done_gen_pattern,
    input  logic               is_equal,
    input  logic               play_again,
    input  logic               in,
    input  logic [GUESS_W-1:0] count,
    output logic               gen_pattern,
    output logic               incr_score,
    output logic               clr,
    output logic               input_handler_en,
    output logic               received_input,
    output logic [GUESS_W-1:0] user_guess
`ifdef CLASSIC_MODE_SCORE_EN
    , output logic [SCORE_W-1:0] score
`endif
);

    state_e state_r;
    state_e next_state_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (start) next_state_s = GEN; else next_state_s = IDLE;
            GEN:     if (done_gen_pattern) next_state_s = INPUT; else next_state_s = GEN;
            INPUT:   if (received_input) next_state_s = CHECK; else next_state_s = INPUT;
            CHECK:   if (is_equal) next_state_s = GEN; else next_state_s = OVER;
            OVER:    if (play_again) next_state_s = GEN; else next_state_s = OVER;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode; incr_score alone depends on the comparator this cycle.
    always_comb begin
        gen_pattern      = 1'b0;
        incr_score       = 1'b0;
        clr              = 1'b0;
        input_handler_en = 1'b0;
        case (state_r)
            IDLE:    clr = 1'b1;
            GEN: begin
                gen_pattern = 1'b1;
                clr         = 1'b1;
            end
            INPUT:   input_handler_en = 1'b1;
            CHECK:   if (is_equal) incr_score = 1'b1; else incr_score = 1'b0;
            OVER:    gen_pattern = 1'b0;
            default: clr = 1'b1;
        endcase
    end

    guess_shifter #(
        .GUESS_W (GUESS_W)
    ) u_shifter (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (in),
        .en             (input_handler_en),
        .clr            (clr),
        .count          (count),
        .received_input (received_input),
        .user_guess     (user_guess)
    );

`ifdef CLASSIC_MODE_SCORE_EN
    logic [SCORE_W-1:0] score_r;
    logic               restart_s;

    assign restart_s = ((state_r == IDLE) && start) || ((state_r == OVER) && play_again);

    // Score restarts with each new game and saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (restart_s) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (incr_score && (score_r != {SCORE_W{1'b1}})) begin
            score_r <= score_r + SCORE_W'(1);
        end
    end

    assign score = score_r;
`endif

endmodule

// File: tb/tb_classic_mode.sv
// Self-checking bench for classic_mode: round sequencing and serial guess capture.
module tb_classic_mode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, done_gen_pattern, is_equal, play_again, in_b;
    logic [15:0] count;
    logic        gen_pattern, incr_score, clr, input_handler_en, received_input;
    logic [15:0] user_guess;
`ifdef CLASSIC_MODE_SCORE_EN
    logic [7:0]  score;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    classic_mode dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .done_gen_pattern (done_gen_pattern),
        .is_equal         (is_equal),
        .play_again       (play_again),
        .in               (in_b),
        .count            (count),
        .gen_pattern      (gen_pattern),
        .incr_score       (incr_score),
        .clr              (clr),
        .input_handler_en (input_handler_en),
        .received_input   (received_input),
        .user_guess       (user_guess)
`ifdef CLASSIC_MODE_SCORE_EN
        , .score          (score)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive nbits serial bits (MSB of bits[nbits-1:0] first); scoreboard the captured word.
    task automatic shift_round(input string tag, input int cnt_val, input int nbits, input logic [31:0] bits);
        int          eff;
        logic [15:0] m;
        bit          popped;
        eff    = (cnt_val > 16) ? 16 : cnt_val;
        m      = 16'h0000;
        popped = 1'b0;
        for (int i = 0; i < eff; i++) m = {m[14:0], bits[nbits-1-i]};
        exp_q.push_back(m);
        count = cnt_val[15:0];
        for (int i = 0; i < nbits; i++) begin
            in_b = bits[nbits-1-i];
            tick();
            check_val({tag, "_rcv"}, {31'd0, received_input}, {31'd0, (i + 1 >= eff)});
            if (received_input && !popped && exp_q.size() > 0) begin
                popped = 1'b1;
                check_val({tag, "_guess"}, {16'd0, user_guess}, {16'd0, exp_q.pop_front()});
            end
        end
        check_val({tag, "_popped"}, {31'd0, popped}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; done_gen_pattern = 1'b0; is_equal = 1'b0;
        play_again = 1'b0; in_b = 1'b0; count = 16'd0;
        #12;
        check_val("rst_clr",  {31'd0, clr}, 32'd1);
        check_val("rst_gen",  {31'd0, gen_pattern}, 32'd0);
        check_val("rst_en",   {31'd0, input_handler_en}, 32'd0);
        check_val("rst_rcv",  {31'd0, received_input}, 32'd0);
        check_val("rst_guess", {16'd0, user_guess}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a game and hold the generator busy for three cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("gen_pat", {31'd0, gen_pattern}, 32'd1);
            check_val("gen_clr", {31'd0, clr}, 32'd1);
            if (i < 2) tick();
        end
        done_gen_pattern = 1'b1;
        tick();
        done_gen_pattern = 1'b0;
        check_val("in_en",  {31'd0, input_handler_en}, 32'd1);
        check_val("in_gen", {31'd0, gen_pattern}, 32'd0);

        shift_round("r1", 5, 5, 32'b10110);
        in_b = 1'b1;
        tick();
        check_val("r1_hold", {16'd0, user_guess}, 32'h0016);
        is_equal = 1'b1;
        #1;
        check_val("chk_incr", {31'd0, incr_score}, 32'd1);
        tick();
        is_equal = 1'b0;
        check_val("incr_pulse", {31'd0, incr_score}, 32'd0);
        check_val("back_gen", {31'd0, gen_pattern}, 32'd1);
        check_val("pre_clr",  {16'd0, user_guess}, 32'h0016);
        tick();
        check_val("clr_guess", {16'd0, user_guess}, 32'd0);
        check_val("clr_rcv",   {31'd0, received_input}, 32'd0);
`ifdef CLASSIC_MODE_SCORE_EN
        check_val("score_1", {24'd0, score}, 32'd1);
`endif

        // Zero-length round, then a wrong answer.
        done_gen_pattern = 1'b1;
        tick();
        done_gen_pattern = 1'b0;
        shift_round("r2", 0, 1, 32'b1);
        tick();
        check_val("chk_noincr", {31'd0, incr_score}, 32'd0);
        tick();
        check_val("over_gen", {31'd0, gen_pattern}, 32'd0);
        check_val("over_clr", {31'd0, clr}, 32'd0);
        check_val("over_en",  {31'd0, input_handler_en}, 32'd0);
        check_val("over_inc", {31'd0, incr_score}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("over_start_ign", {31'd0, gen_pattern}, 32'd0);
        play_again = 1'b1;
        tick();
        play_again = 1'b0;
        check_val("replay_gen", {31'd0, gen_pattern}, 32'd1);
`ifdef CLASSIC_MODE_SCORE_EN
        check_val("score_0", {24'd0, score}, 32'd0);
`endif

        // Oversized count clamps to 16 bits.
        done_gen_pattern = 1'b1;
        tick();
        done_gen_pattern = 1'b0;
        shift_round("r3", 20, 16, 32'h0000A5C3);
        in_b = 1'b0;
        tick();
        check_val("r3_hold", {16'd0, user_guess}, 32'h0000A5C3);
        is_equal = 1'b1;
        tick();
        is_equal = 1'b0;
        tick();

        // Asynchronous reset mid-shift.
        done_gen_pattern = 1'b1;
        tick();
        done_gen_pattern = 1'b0;
        count = 16'd8;
        in_b  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("mid_rcv", {31'd0, received_input}, 32'd0);
        check_val("mid_guess", {16'd0, user_guess}, 32'h0007);
        rst_n = 1'b0;
        #1;
        check_val("arst_clr",   {31'd0, clr}, 32'd1);
        check_val("arst_en",    {31'd0, input_handler_en}, 32'd0);
        check_val("arst_guess", {16'd0, user_guess}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("idle_gen", {31'd0, gen_pattern}, 32'd0);
        check_val("idle_clr", {31'd0, clr}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
